// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : One registered AND/OR/XOR/NOR unit shared round-robin among
//            NUM_REQ requesters. Optional macro LOGIC_ARB_STATS_EN adds
//            o_op_count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
  input  logic [NUM_REQ*2-1:0]       i_req_op,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [WIDTH-1:0]           o_rsp_data,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic                       o_busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [31:0]                o_op_count
`endif
);

  localparam logic [ID_W:0] c_num_req = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [1:0]        r_op;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_any;
  logic [ID_W:0]        w_offset;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_grant_ext;
  logic [ID_W-1:0]      w_grant_id;
  logic [ID_W-1:0]      w_next_ptr;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic [1:0]           w_sel_op;
  logic [WIDTH-1:0]     w_result;

  // Rotate valids so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign w_dbl = {i_req_valid, i_req_valid};
  assign w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);

  always_comb begin
    w_any    = 1'b0;
    w_offset = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any    = 1'b1;
        w_offset = (ID_W+1)'(j);
      end
    end
  end

  assign w_sum       = {1'b0, r_rr_ptr} + w_offset;
  assign w_grant_ext = (w_sum >= c_num_req) ? (w_sum - c_num_req) : w_sum;
  assign w_grant_id  = w_grant_ext[ID_W-1:0];
  assign w_next_ptr  = ((w_grant_ext + 1'b1) == c_num_req) ? '0 : (w_grant_id + 1'b1);
  assign w_accept    = (r_state == ST_IDLE) && w_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = ~rst && w_accept && (w_grant_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_a  = i_req_a[i*WIDTH +: WIDTH];
        w_sel_b  = i_req_b[i*WIDTH +: WIDTH];
        w_sel_op = i_req_op[i*2 +: 2];
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a & r_b;
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      default: w_result = ~(r_a | r_b);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_op     <= w_sel_op;
            r_id     <= w_grant_id;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          o_rsp_data  <= w_result;
          o_rsp_id    <= r_id;
          o_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          o_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_op_count <= '0;
    end else if ((r_state == ST_RESP) && o_rsp_valid && i_rsp_ready) begin
      o_op_count <= o_op_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, corner sequences
// and randomized transactions against a priority-list reference model.
`default_nettype none

module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*W-1:0] i_req_a;
  logic [NREQ*W-1:0] i_req_b;
  logic [NREQ*2-1:0] i_req_op;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [W-1:0]      o_rsp_data;
  logic [1:0]        o_rsp_id;
  logic              o_busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [31:0]       o_op_count;
`endif

  logic_unit_arbiter #(.WIDTH(W), .NUM_REQ(NREQ), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_op    (i_req_op),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_id    (o_rsp_id),
    .o_busy      (o_busy)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .o_op_count  (o_op_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;
  int prio[$];
  int gq[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Reference: result by opcode definition, arbitration as a rotating priority list.
  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic model_reset();
    prio = {0, 1, 2, 3};
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] m);
    int r = -1;
    for (int i = prio.size() - 1; i >= 0; i--)
      if (m[prio[i]]) r = prio[i];
    return r;
  endfunction

  task automatic model_accept(input int g);
    int t;
    while (prio[0] != (g + 1) % NREQ) begin
      t = prio.pop_front();
      prio.push_back(t);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v = 1;
    return (g < 0) ? '0 : (v << g);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] exp);
    @(negedge clk);
    i_req_a[id*W +: W] = a;
    i_req_b[id*W +: W] = b;
    i_req_op[id*2 +: 2] = op;
    i_req_valid = onehot(id);
    i_rsp_ready = 1'b1;
    #1;
    chk("grant_single", o_req_ready, onehot(model_grant(onehot(id))));
    @(posedge clk); #1;
    model_accept(id);
    i_req_valid = '0;
    chk("exec_no_valid", {o_rsp_valid, o_busy, o_req_ready}, {1'b0, 1'b1, 4'b0000});
    @(posedge clk); #1;
    chk("resp_valid", o_rsp_valid, 1);
    chk("resp_data", o_rsp_data, exp);
    chk("resp_id", o_rsp_id, id);
    @(posedge clk); #1;
    chk("back_idle", {o_rsp_valid, o_busy}, 2'b00);
  endtask

  task automatic collect_grants(input logic [NREQ-1:0] mask, input int n);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] r;
    int got = 0;
    int cyc = 0;
    int g;
    bit multi = 0;
    gq.delete();
    pend = mask;
    @(negedge clk);
    i_rsp_ready = 1'b1;
    i_req_valid = pend;
    while (got < n && cyc < 100) begin
      #1;
      r = o_req_ready;
      if ($countones(r) > 1) multi = 1;
      if (r != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (r[i]) g = i;
        chk("rr_grant", g, model_grant(pend));
        model_accept(g);
        gq.push_back(g);
        got++;
        @(posedge clk); #1;
        pend[g] = 1'b0;
        i_req_valid = pend;
      end
      @(negedge clk);
      cyc++;
    end
    chk("ready_onehot", multi, 0);
    chk("grant_count", got, n);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ea;
    logic [31:0] hold_d;
    logic [NREQ-1:0] m;
    int g;
    int wt;
    int stall;

    tbl[0] = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'hF000F000};
    tbl[1] = '{2, 32'hAAAA5555, 32'h0F0F0F0F, 2'd0, 32'h0A0A0505};
    tbl[2] = '{2, 32'hAAAA5555, 32'h0F0F0F0F, 2'd1, 32'hAFAF5F5F};
    tbl[3] = '{2, 32'hAAAA5555, 32'h0F0F0F0F, 2'd2, 32'hA5A55A5A};
    tbl[4] = '{2, 32'hAAAA5555, 32'h0F0F0F0F, 2'd3, 32'h5050A0A0};
    tbl[5] = '{3, 32'h12345678, 32'hFFFF0000, 2'd3, 32'h0000A987};

    rst = 1'b1;
    i_req_valid = '1;
    i_req_a = '0;
    i_req_b = '0;
    i_req_op = '0;
    i_rsp_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_outputs", {o_rsp_valid, o_busy, o_req_ready}, 6'd0);
    chk("reset_data", {o_rsp_data, o_rsp_id}, 34'd0);
    @(negedge clk);
    i_req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);

    // All four contend from reset, two rounds.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      collect_grants(4'b1111, 4);
      for (int i = 0; i < 4; i++) chk("rr_order", gq[i], i);
    end

    // Backpressure with another requester waiting.
    @(negedge clk);
    i_rsp_ready = 1'b0;
    i_req_a[1*W +: W] = 32'hDEADBEEF;
    i_req_b[1*W +: W] = 32'h0000FFFF;
    i_req_op[1*2 +: 2] = 2'd2;
    i_req_valid = 4'b0010;
    #1;
    chk("bp_grant", o_req_ready, onehot(model_grant(4'b0010)));
    @(posedge clk); #1;
    model_accept(1);
    i_req_valid = 4'b1000;
    @(posedge clk); #1;
    chk("bp_first", {o_rsp_valid, o_rsp_id, o_rsp_data}, {1'b1, 2'd1, 32'hDEAD4110});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", {o_rsp_valid, o_rsp_id, o_rsp_data}, {1'b1, 2'd1, 32'hDEAD4110});
      chk("bp_ready_busy", {o_req_ready, o_busy}, {4'b0000, 1'b1});
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {o_rsp_valid, o_busy}, 2'b00);
    chk("bp_next_ready", o_req_ready, onehot(model_grant(4'b1000)));
    chk("bp_data_kept", {o_rsp_id, o_rsp_data}, {2'd1, 32'hDEAD4110});
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    @(negedge clk);
    chk("drop_no_accept", o_busy, 0);

    // Async reset while in RESP, then priority restarts at 0.
    @(negedge clk);
    i_req_valid = 4'b0100;
    @(posedge clk); #1;
    model_accept(2);
    i_req_valid = '0;
    @(posedge clk); #1;
    chk("pre_rst_resp", o_rsp_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {o_rsp_valid, o_busy}, 2'b00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    collect_grants(4'b1010, 2);
    chk("rst_order0", gq[0], 1);
    chk("rst_order1", gq[1], 3);

    // Randomized transactions.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      i_req_a = {$urandom, $urandom, $urandom, $urandom};
      i_req_b = {$urandom, $urandom, $urandom, $urandom};
      i_req_op = 8'($urandom);
      m = 4'($urandom_range(1, 15));
      i_req_valid = m;
      i_rsp_ready = 1'b0;
      g = model_grant(m);
      #1;
      chk("rnd_grant", o_req_ready, onehot(g));
      ea = lu(i_req_a[g*W +: W], i_req_b[g*W +: W], i_req_op[g*2 +: 2]);
      @(posedge clk); #1;
      model_accept(g);
      i_req_valid = '0;
      wt = 0;
      while (!o_rsp_valid && wt < 8) begin
        @(negedge clk);
        wt++;
      end
      chk("rnd_rsp_seen", o_rsp_valid, 1);
      chk("rnd_data", o_rsp_data, ea);
      chk("rnd_id", o_rsp_id, g);
      hold_d = o_rsp_data;
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      chk("rnd_hold", {o_rsp_valid, o_rsp_data}, {1'b1, ea});
      i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("rnd_done", {o_rsp_valid, o_busy}, 2'b00);
      i_rsp_ready = 1'b0;
    end

`ifdef LOGIC_ARB_STATS_EN
    do_reset();
    chk("cnt_reset", o_op_count, 0);
    for (int k = 0; k < 3; k++)
      run_single(k, 32'h0000FFFF, 32'h00FF00FF, 2'd1, 32'h00FFFFFF);
    chk("cnt_three", o_op_count, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cnt_async_clear", o_op_count, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
